fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, the PC fetched first after reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 imem_req  output  1  instruction-memory read request.
REQ-005 imem_addr  output  32  word address of the outstanding request; bits [1:0] always 0.
REQ-006 imem_ready  input  1  imem_data valid for the outstanding request this cycle.
REQ-007 imem_data  input  32  instruction word returned.
REQ-008 stall  input  1  ID stage cannot accept a new IF/ID entry this cycle.
REQ-009 takeBranch  input  1  redirect request from the jump/branch unit.
REQ-010 branchPC  input  32  redirect target; bits [1:0] ignored.
REQ-011 if_valid  output  1  IF/ID entry holds a real instruction.
REQ-012 if_instr  output  32  IF/ID instruction; 32'h0 when bubble.
REQ-013 if_pc  output  32  address of if_instr.
REQ-014 if_pc4  output  32  if_pc+4, mod 2^32; feeds the jump/branch unit's inputPC.

Function
REQ-015 States SHALL be REQ (request outstanding), HOLD (word buffered, ID stalled), DISCARD (wrong-path response pending).
REQ-016 In REQ and DISCARD, imem_req SHALL be 1 and imem_addr SHALL stay stable until the cycle imem_ready=1; in HOLD, imem_req SHALL be 0.
REQ-017 REQ, imem_ready=1, stall=0, takeBranch=0: IF/ID SHALL load {1, imem_data, addr, addr+4}; pc<=addr+4; next request issues the following cycle (1-cycle minimum latency request->IF/ID).
REQ-018 REQ, imem_ready=1, stall=1: word and addr SHALL be buffered; IF/ID unchanged; go HOLD.
REQ-019 HOLD, stall=0, takeBranch=0: IF/ID SHALL load the buffered word; pc<=addr+4; go REQ.
REQ-020 REQ, imem_ready=0: IF/ID SHALL load bubble (valid 0, instr 0) if stall=0, hold if stall=1.
REQ-021 takeBranch SHALL be honoured only when stall=0; when stall=1 it SHALL be ignored.
REQ-022 Honoured takeBranch SHALL: pc<={branchPC[31:2],2'b00}; IF/ID<=bubble; any buffered word discarded.
REQ-023 Honoured takeBranch in REQ with imem_ready=1 or in HOLD: go REQ, next imem_addr=target.
REQ-024 Honoured takeBranch in REQ with imem_ready=0: go DISCARD; imem_addr unchanged.
REQ-025 DISCARD: the response SHALL be dropped (IF/ID not loaded with it); on imem_ready=1 go REQ at pc; a further honoured takeBranch in DISCARD SHALL overwrite pc and remain in DISCARD.
REQ-026 PC arithmetic SHALL wrap mod 2^32 (32'hFFFF_FFFC+4 = 0).
REQ-027 takeBranch has priority over a same-cycle imem_ready; stall has priority over everything except rst.

Reset
REQ-028 rst=1 SHALL asynchronously force: state REQ, pc=RESET_PC, imem_addr=RESET_PC, imem_req=0 while rst held, if_valid=0, if_instr=0, if_pc=0, if_pc4=0, buffer cleared.
REQ-029 First request SHALL issue in the first clk edge's cycle after rst deasserts; reset mid-request SHALL abandon it, and any imem_ready during reset SHALL be ignored.

Verification
REQ-030 Reset, imem_ready=1 always, stall=0 -> if_pc 0,4,8,12 on consecutive cycles, if_valid=1 from 2nd cycle, if_pc4=if_pc+4.
REQ-031 imem_ready low 3 cycles at addr 8 -> imem_addr=8 held 4 cycles, 3 bubbles, then if_pc=8.
REQ-032 stall=1 for 2 cycles while word at addr 16 returns -> IF/ID frozen, imem_req=0 in HOLD, on release if_pc=16 with correct word, next request addr 20.
REQ-033 takeBranch=1, branchPC=32'h0000_0103, imem_ready=0 -> DISCARD; late response dropped; next if_pc=32'h100, one-plus bubbles with if_valid=0.
REQ-034 takeBranch=1 with stall=1 -> no redirect, pc sequence unchanged.
REQ-035 RESET_PC=32'hFFFF_FFF8 -> if_pc FFFF_FFF8, FFFF_FFFC, 0000_0000; rst asserted mid-wait -> outputs zero immediately, restart at RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage feeding the IF/ID register.
// At most one instruction-memory request is outstanding at a time.
// A word that returns while ID is stalled is parked in a one-entry buffer.
// A redirect made while a response is still pending leaves that request
// in flight, and the response is dropped when it arrives.
//
// Ports:
//   clk, rst                 clock, async active-high reset
//   imem_req, imem_addr      outstanding read request and its word address
//   imem_ready, imem_data    response handshake and returned word
//   stall                    ID cannot accept a new IF/ID entry
//   takeBranch, branchPC     redirect request and target
//   if_valid, if_instr       IF/ID entry (instr is 0 on a bubble)
//   if_pc, if_pc4            address of if_instr and that address + 4
//
// state   | meaning
// S_REQ     | request at imem_addr outstanding, response goes to IF/ID
// S_HOLD    | returned word buffered while ID is stalled, no request
// S_DISCARD | wrong-path response pending, r_pc holds the redirect target
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_data,
  input  logic        stall,
  input  logic        takeBranch,
  input  logic [31:0] branchPC,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc4
);

  typedef enum logic [1:0] {S_REQ, S_HOLD, S_DISCARD} state_t;

  localparam logic [31:0] RESET_ADDR = {RESET_PC[31:2], 2'b00};

  state_t      r_state, w_state_nxt;
  logic        r_active;
  logic [31:0] r_addr, w_addr_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic [31:0] r_buf, w_buf_nxt;
  logic        r_valid, w_valid_nxt;
  logic [31:0] r_instr, w_instr_nxt;
  logic [31:0] r_ifpc, w_ifpc_nxt;
  logic [31:0] r_ifpc4, w_ifpc4_nxt;

  logic [31:0] w_target;
  logic [31:0] w_addr4;
  logic        w_unused;

  assign w_target = {branchPC[31:2], 2'b00};
  assign w_addr4  = r_addr + 32'd4;
  assign w_unused = &{1'b0, branchPC[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_REQ;
      r_active <= 1'b0;
      r_addr   <= RESET_ADDR;
      r_pc     <= RESET_ADDR;
      r_buf    <= 32'h0;
      r_valid  <= 1'b0;
      r_instr  <= 32'h0;
      r_ifpc   <= 32'h0;
      r_ifpc4  <= 32'h0;
    end else begin
      // r_active holds off the first request until one edge after reset
      // release, so a response seen during or at reset release is ignored.
      r_active <= 1'b1;
      r_state  <= w_state_nxt;
      r_addr   <= w_addr_nxt;
      r_pc     <= w_pc_nxt;
      r_buf    <= w_buf_nxt;
      r_valid  <= w_valid_nxt;
      r_instr  <= w_instr_nxt;
      r_ifpc   <= w_ifpc_nxt;
      r_ifpc4  <= w_ifpc4_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_pc_nxt    = r_pc;
    w_buf_nxt   = r_buf;
    w_valid_nxt = r_valid;
    w_instr_nxt = r_instr;
    w_ifpc_nxt  = r_ifpc;
    w_ifpc4_nxt = r_ifpc4;

    if (r_active) begin
      case (r_state)
        S_REQ: begin
          if (stall) begin
            if (imem_ready) begin
              w_buf_nxt   = imem_data;
              w_state_nxt = S_HOLD;
            end
          end else if (takeBranch) begin
            w_valid_nxt = 1'b0;
            w_instr_nxt = 32'h0;
            w_pc_nxt    = w_target;
            if (imem_ready) w_addr_nxt = w_target;
            else            w_state_nxt = S_DISCARD;
          end else if (imem_ready) begin
            w_valid_nxt = 1'b1;
            w_instr_nxt = imem_data;
            w_ifpc_nxt  = r_addr;
            w_ifpc4_nxt = w_addr4;
            w_addr_nxt  = w_addr4;
            w_pc_nxt    = w_addr4;
          end else begin
            w_valid_nxt = 1'b0;
            w_instr_nxt = 32'h0;
          end
        end
        S_HOLD: begin
          // r_addr still holds the address of the buffered word here.
          if (!stall) begin
            w_state_nxt = S_REQ;
            w_buf_nxt   = 32'h0;
            if (takeBranch) begin
              w_valid_nxt = 1'b0;
              w_instr_nxt = 32'h0;
              w_addr_nxt  = w_target;
              w_pc_nxt    = w_target;
            end else begin
              w_valid_nxt = 1'b1;
              w_instr_nxt = r_buf;
              w_ifpc_nxt  = r_addr;
              w_ifpc4_nxt = w_addr4;
              w_addr_nxt  = w_addr4;
              w_pc_nxt    = w_addr4;
            end
          end
        end
        S_DISCARD: begin
          // The pending response is consumed whether or not ID is stalled;
          // only the IF/ID update waits on stall.
          if (!stall) begin
            w_valid_nxt = 1'b0;
            w_instr_nxt = 32'h0;
            if (takeBranch) w_pc_nxt = w_target;
          end
          if (imem_ready) begin
            w_state_nxt = S_REQ;
            w_addr_nxt  = (!stall && takeBranch) ? w_target : r_pc;
          end
        end
        default: w_state_nxt = S_REQ;
      endcase
    end
  end

  assign imem_req  = r_active && (r_state != S_HOLD);
  assign imem_addr = r_addr;
  assign if_valid  = r_valid;
  assign if_instr  = r_instr;
  assign if_pc     = r_ifpc;
  assign if_pc4    = r_ifpc4;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, imem_req, imem_ready, stall, takeBranch, if_valid;
  logic [31:0] imem_addr, imem_data, branchPC, if_instr, if_pc, if_pc4;

  logic        rst2, imem_req2, imem_ready2, if_valid2;
  logic [31:0] imem_addr2, imem_data2, if_instr2, if_pc2, if_pc42;

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_data(imem_data), .stall(stall),
    .takeBranch(takeBranch), .branchPC(branchPC), .if_valid(if_valid),
    .if_instr(if_instr), .if_pc(if_pc), .if_pc4(if_pc4));

  fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clk(clk), .rst(rst2), .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_ready(imem_ready2), .imem_data(imem_data2), .stall(1'b0),
    .takeBranch(1'b0), .branchPC(32'h0), .if_valid(if_valid2),
    .if_instr(if_instr2), .if_pc(if_pc2), .if_pc4(if_pc42));

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        rdy, stl, tb;
    logic [31:0] bpc;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_v;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input logic rdy, input logic stl, input logic tb,
                              input logic [31:0] bpc, input logic req,
                              input logic [31:0] addr, input logic v,
                              input logic [31:0] pc);
    vec_t r;
    r.rdy = rdy; r.stl = stl; r.tb = tb; r.bpc = bpc;
    r.exp_req = req; r.exp_addr = addr; r.exp_v = v; r.exp_pc = pc;
    return r;
  endfunction

  task automatic check_if(input string tag, input logic ev, input logic [31:0] epc,
                          input logic [31:0] ei);
    chk({tag, " if_valid"}, {31'h0, if_valid}, {31'h0, ev});
    chk({tag, " if_instr"}, if_instr, ei);
    if (ev) begin
      chk({tag, " if_pc"}, if_pc, epc);
      chk({tag, " if_pc4"}, if_pc4, epc + 32'd4);
    end
  endtask

  // Asserts reset mid-cycle, checks the cleared outputs, releases on a negedge.
  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1; imem_ready = 1'b1; imem_data = 32'hDEAD_BEEF;
    #1;
    chk("rst imem_req", {31'h0, imem_req}, 32'h0);
    chk("rst imem_addr", imem_addr, 32'h0);
    chk("rst if_valid", {31'h0, if_valid}, 32'h0);
    chk("rst if_instr", if_instr, 32'h0);
    chk("rst if_pc", if_pc, 32'h0);
    chk("rst if_pc4", if_pc4, 32'h0);
    @(posedge clk); #1;
    chk("rst held if_valid", {31'h0, if_valid}, 32'h0);
    chk("rst held imem_req", {31'h0, imem_req}, 32'h0);
    @(negedge clk);
    rst = 1'b0; imem_ready = 1'b0; stall = 1'b0; takeBranch = 1'b0;
  endtask

  // Reference model: one outstanding address, an optional redirect target
  // still waiting for the wrong-path response, and a queue of parked words.
  logic        m_act, m_wrong;
  logic [31:0] m_addr, m_tgt;
  logic [31:0] m_buf[$];
  logic        e_v;
  logic [31:0] e_i, e_pc;

  task automatic model_bubble();
    e_v = 1'b0; e_i = 32'h0;
  endtask

  task automatic model_deliver(input logic [31:0] w, input logic [31:0] a);
    e_v = 1'b1; e_i = w; e_pc = a; m_addr = a + 32'd4;
  endtask

  task automatic model_edge(input logic rdy, input logic stl, input logic tb,
                            input logic [31:0] bpc);
    logic [31:0] t;
    t = bpc & 32'hFFFF_FFFC;
    if (!m_act) begin
      m_act = 1'b1;
    end else if (m_buf.size() != 0) begin
      if (!stl) begin
        if (tb) begin
          model_bubble();
          m_buf.delete();
          m_addr = t;
        end else begin
          model_deliver(m_buf.pop_front(), m_addr);
        end
      end
    end else if (m_wrong) begin
      if (!stl) begin
        model_bubble();
        if (tb) m_tgt = t;
      end
      if (rdy) begin
        m_wrong = 1'b0;
        m_addr = m_tgt;
      end
    end else begin
      if (stl) begin
        if (rdy) m_buf.push_back(mem_word(m_addr));
      end else if (tb) begin
        model_bubble();
        if (rdy) m_addr = t;
        else begin
          m_wrong = 1'b1;
          m_tgt = t;
        end
      end else if (rdy) begin
        model_deliver(mem_word(m_addr), m_addr);
      end else begin
        model_bubble();
      end
    end
  endtask

  initial begin
    rst = 1'b1; imem_ready = 1'b0; imem_data = 32'h0; stall = 1'b0;
    takeBranch = 1'b0; branchPC = 32'h0;
    rst2 = 1'b1; imem_ready2 = 1'b0; imem_data2 = 32'h0;

    vt.push_back(mk(1, 0, 0, 32'h0,   0, 32'h0,   0, 32'h0));
    vt.push_back(mk(1, 0, 0, 32'h0,   1, 32'h0,   1, 32'h0));
    vt.push_back(mk(1, 0, 0, 32'h0,   1, 32'h4,   1, 32'h4));
    vt.push_back(mk(0, 0, 0, 32'h0,   1, 32'h8,   0, 32'h0));
    vt.push_back(mk(0, 0, 0, 32'h0,   1, 32'h8,   0, 32'h0));
    vt.push_back(mk(0, 0, 0, 32'h0,   1, 32'h8,   0, 32'h0));
    vt.push_back(mk(1, 0, 0, 32'h0,   1, 32'h8,   1, 32'h8));
    vt.push_back(mk(1, 0, 0, 32'h0,   1, 32'hC,   1, 32'hC));
    vt.push_back(mk(1, 1, 0, 32'h0,   1, 32'h10,  1, 32'hC));
    vt.push_back(mk(0, 1, 0, 32'h0,   0, 32'h0,   1, 32'hC));
    vt.push_back(mk(0, 0, 0, 32'h0,   0, 32'h0,   1, 32'h10));
    vt.push_back(mk(1, 0, 0, 32'h0,   1, 32'h14,  1, 32'h14));
    vt.push_back(mk(0, 0, 1, 32'h103, 1, 32'h18,  0, 32'h0));
    vt.push_back(mk(0, 0, 0, 32'h0,   1, 32'h18,  0, 32'h0));
    vt.push_back(mk(1, 0, 0, 32'h0,   1, 32'h18,  0, 32'h0));
    vt.push_back(mk(1, 0, 0, 32'h0,   1, 32'h100, 1, 32'h100));
    vt.push_back(mk(1, 1, 1, 32'h200, 1, 32'h104, 1, 32'h100));
    vt.push_back(mk(0, 0, 0, 32'h0,   0, 32'h0,   1, 32'h104));
    vt.push_back(mk(1, 0, 0, 32'h0,   1, 32'h108, 1, 32'h108));
    vt.push_back(mk(0, 1, 1, 32'h500, 1, 32'h10C, 1, 32'h108));
    vt.push_back(mk(1, 0, 0, 32'h0,   1, 32'h10C, 1, 32'h10C));
    vt.push_back(mk(1, 0, 1, 32'h41,  1, 32'h110, 0, 32'h0));
    vt.push_back(mk(1, 0, 0, 32'h0,   1, 32'h40,  1, 32'h40));
    vt.push_back(mk(1, 1, 0, 32'h0,   1, 32'h44,  1, 32'h40));
    vt.push_back(mk(0, 0, 1, 32'h80,  0, 32'h0,   0, 32'h0));
    vt.push_back(mk(1, 0, 0, 32'h0,   1, 32'h80,  1, 32'h80));
    vt.push_back(mk(0, 0, 1, 32'h300, 1, 32'h84,  0, 32'h0));
    vt.push_back(mk(0, 0, 1, 32'h402, 1, 32'h84,  0, 32'h0));
    vt.push_back(mk(1, 0, 0, 32'h0,   1, 32'h84,  0, 32'h0));
    vt.push_back(mk(1, 0, 0, 32'h0,   1, 32'h400, 1, 32'h400));

    // Directed table on the RESET_PC=0 instance.
    do_reset();
    for (int k = 0; k < vt.size(); k++) begin
      imem_ready = vt[k].rdy; stall = vt[k].stl;
      takeBranch = vt[k].tb;  branchPC = vt[k].bpc;
      imem_data  = vt[k].rdy ? mem_word(vt[k].exp_addr) : $urandom;
      #1;
      chk($sformatf("vec%0d imem_req", k), {31'h0, imem_req}, {31'h0, vt[k].exp_req});
      if (vt[k].exp_req) chk($sformatf("vec%0d imem_addr", k), imem_addr, vt[k].exp_addr);
      @(posedge clk); #1;
      check_if($sformatf("vec%0d", k), vt[k].exp_v, vt[k].exp_pc,
               vt[k].exp_v ? mem_word(vt[k].exp_pc) : 32'h0);
      @(negedge clk);
    end

    // Wrap-around start address, then reset while a request is waiting.
    rst2 = 1'b0;
    #1 chk("wrap first-cycle imem_req", {31'h0, imem_req2}, 32'h0);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      logic [31:0] a;
      a = 32'hFFFF_FFF8 + 32'(k * 4);
      imem_ready2 = 1'b1; imem_data2 = mem_word(a);
      #1 chk($sformatf("wrap%0d imem_addr", k), imem_addr2, a);
      @(posedge clk); #1;
      chk($sformatf("wrap%0d if_pc", k), if_pc2, a);
      chk($sformatf("wrap%0d if_pc4", k), if_pc42, a + 32'd4);
      chk($sformatf("wrap%0d if_instr", k), if_instr2, mem_word(a));
      @(negedge clk);
    end
    imem_ready2 = 1'b0;
    #2 rst2 = 1'b1; imem_ready2 = 1'b1;
    #1;
    chk("wrap rst if_valid", {31'h0, if_valid2}, 32'h0);
    chk("wrap rst if_instr", if_instr2, 32'h0);
    chk("wrap rst if_pc", if_pc2, 32'h0);
    chk("wrap rst if_pc4", if_pc42, 32'h0);
    chk("wrap rst imem_req", {31'h0, imem_req2}, 32'h0);
    chk("wrap rst imem_addr", imem_addr2, 32'hFFFF_FFF8);
    @(negedge clk);
    rst2 = 1'b0; imem_ready2 = 1'b0;
    @(negedge clk);
    imem_ready2 = 1'b1; imem_data2 = mem_word(32'hFFFF_FFF8);
    #1 chk("restart imem_addr", imem_addr2, 32'hFFFF_FFF8);
    @(posedge clk); #1;
    chk("restart if_pc", if_pc2, 32'hFFFF_FFF8);
    chk("restart if_valid", {31'h0, if_valid2}, 32'h1);
    @(negedge clk);
    imem_ready2 = 1'b0;

    // Randomized run against the reference model.
    do_reset();
    m_act = 1'b0; m_wrong = 1'b0; m_addr = 32'h0; m_tgt = 32'h0;
    m_buf.delete(); e_v = 1'b0; e_i = 32'h0; e_pc = 32'h0;
    for (int k = 0; k < 400; k++) begin
      logic rdy, stl, tb, ereq;
      logic [31:0] bpc;
      rdy = ($urandom_range(0, 9) < 6);
      stl = ($urandom_range(0, 9) < 3);
      tb  = ($urandom_range(0, 9) == 0);
      bpc = $urandom;
      imem_ready = rdy; stall = stl; takeBranch = tb; branchPC = bpc;
      imem_data = rdy ? mem_word(m_addr) : $urandom;
      ereq = m_act && (m_buf.size() == 0);
      #1;
      chk($sformatf("rnd%0d imem_req", k), {31'h0, imem_req}, {31'h0, ereq});
      if (ereq) chk($sformatf("rnd%0d imem_addr", k), imem_addr, m_addr);
      @(posedge clk);
      model_edge(rdy, stl, tb, bpc);
      #1;
      check_if($sformatf("rnd%0d", k), e_v, e_pc, e_i);
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
